// File: rtl/lfsr_sequencer.sv
// Parametrised Fibonacci/Galois LFSR engine with a start/busy/done handshake.
// A run first scans the tap mask serially to count taps, then advances the register a programmed number of times.
module lfsr_sequencer #(
  parameter int              WIDTH        = 8,
  parameter int              CNT_W        = 8,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         seed_load,
  input  logic [WIDTH-1:0]             seed,
  input  logic [WIDTH-1:0]             tap_mask,
  input  logic [CNT_W-1:0]             steps,
  input  logic                         mode,
  output logic [WIDTH-1:0]             value,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(WIDTH+1)-1:0]   tap_count,
  output logic [CNT_W-1:0]             steps_done
);

  localparam int TCW = $clog2(WIDTH+1);
  localparam logic [TCW-1:0]   TC_ONE    = {{(TCW-1){1'b0}}, 1'b1};
  localparam logic [TCW-1:0]   SCAN_LAST = TCW'(WIDTH-1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  value_q, value_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [TCW-1:0]    tap_count_q, tap_count_d;
  logic [CNT_W-1:0]  steps_done_q, steps_done_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  scan_mask_q, scan_mask_d;
  logic [CNT_W-1:0]  steps_q, steps_d;
  logic              mode_q, mode_d;
  logic [TCW-1:0]    tap_cnt_q, tap_cnt_d;
  logic [TCW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [CNT_W-1:0]  steps_next_s;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] m,
                                                 input logic             galois);
    if (galois) begin
      lfsr_step = {v[WIDTH-2:0], 1'b0} ^ ({WIDTH{v[WIDTH-1]}} & m);
    end else begin
      lfsr_step = {v[WIDTH-2:0], ^(v & m)};
    end
  endfunction

  // Next-state and registered-output computation for the run sequencer.
  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    tap_count_d  = tap_count_q;
    steps_done_d = steps_done_q;
    mask_d       = mask_q;
    scan_mask_d  = scan_mask_q;
    steps_d      = steps_q;
    mode_d       = mode_q;
    tap_cnt_d    = tap_cnt_q;
    scan_cnt_d   = scan_cnt_q;
    steps_next_s = steps_done_q + CNT_ONE;

    case (state_q)
      IDLE: begin
        // The cycle showing the done pulse still belongs to the finished run.
        if (!done_q) begin
          if (seed_load) begin
            value_d = seed;
          end else begin
            value_d = value_q;
          end
          if (start) begin
            mask_d       = tap_mask;
            scan_mask_d  = tap_mask;
            steps_d      = steps;
            mode_d       = mode;
            err_d        = 1'b0;
            steps_done_d = {CNT_W{1'b0}};
            tap_cnt_d    = {TCW{1'b0}};
            scan_cnt_d   = {TCW{1'b0}};
            busy_d       = 1'b1;
            state_d      = SCAN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SCAN: begin
        scan_mask_d = scan_mask_q >> 1;
        tap_cnt_d   = tap_cnt_q + {{(TCW-1){1'b0}}, scan_mask_q[0]};
        scan_cnt_d  = scan_cnt_q + TC_ONE;
        if (scan_cnt_q == SCAN_LAST) begin
          tap_count_d = tap_cnt_d;
          if ((tap_cnt_d == {TCW{1'b0}}) || (value_q == {WIDTH{1'b0}})) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (steps_q == {CNT_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = SCAN;
        end
      end

      RUN: begin
        value_d      = lfsr_step(value_q, mask_q, mode_q);
        steps_done_d = steps_next_s;
        if (steps_next_s == steps_q) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      value_q      <= SEED_DEFAULT;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      tap_count_q  <= {TCW{1'b0}};
      steps_done_q <= {CNT_W{1'b0}};
      mask_q       <= {WIDTH{1'b0}};
      scan_mask_q  <= {WIDTH{1'b0}};
      steps_q      <= {CNT_W{1'b0}};
      mode_q       <= 1'b0;
      tap_cnt_q    <= {TCW{1'b0}};
      scan_cnt_q   <= {TCW{1'b0}};
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      tap_count_q  <= tap_count_d;
      steps_done_q <= steps_done_d;
      mask_q       <= mask_d;
      scan_mask_q  <= scan_mask_d;
      steps_q      <= steps_d;
      mode_q       <= mode_d;
      tap_cnt_q    <= tap_cnt_d;
      scan_cnt_q   <= scan_cnt_d;
    end
  end

  assign value      = value_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign tap_count  = tap_count_q;
  assign steps_done = steps_done_q;

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Scoreboard bench for lfsr_sequencer (WIDTH=8): stimulus pushes expected results,
// a negedge monitor checks every LFSR step and every done pulse.
module tb_lfsr_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, seed_load, mode;
  logic [7:0] seed, tap_mask, steps;
  logic [7:0] value;
  logic       busy, done, err;
  logic [3:0] tap_count;
  logic [7:0] steps_done;

  lfsr_sequencer #(.WIDTH(8), .CNT_W(8), .SEED_DEFAULT(8'h01)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed(seed),
    .tap_mask(tap_mask), .steps(steps), .mode(mode), .value(value), .busy(busy),
    .done(done), .err(err), .tap_count(tap_count), .steps_done(steps_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] value;
    logic       err;
    logic [3:0] tcnt;
    logic [7:0] sdone;
    int         busy_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] step_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         busy_cnt = 0;
  logic [7:0] prev_val = 8'h00;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: checks each step value while busy and the full result at each done pulse.
  always @(negedge clk) begin
    exp_t ex;
    logic [7:0] sv;
    if (rst) begin
      busy_cnt = 0;
      prev_val = value;
    end else begin
      if (busy && (value !== prev_val) && (step_q.size() > 0)) begin
        sv = step_q.pop_front();
        chk("step_value", value, sv);
      end
      prev_val = value;
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          ex = exp_q.pop_front();
          chk("value", value, ex.value);
          chk("err", err, ex.err);
          chk("tap_count", tap_count, ex.tcnt);
          chk("steps_done", steps_done, ex.sdone);
          chk("busy_cycles", busy_cnt, ex.busy_cyc);
          chk("busy_at_done", busy, 0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic load_seed(input logic [7:0] s);
    @(negedge clk);
    seed_load = 1'b1;
    seed      = s;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", done, 1);
  endtask

  task automatic issue(input logic [7:0] m, input logic [7:0] n, input logic md,
                       input logic [7:0] ev, input logic ee, input logic [3:0] et,
                       input logic [7:0] es, input int eb);
    exp_t ex;
    @(negedge clk);
    tap_mask = m;
    steps    = n;
    mode     = md;
    start    = 1'b1;
    ex.value = ev; ex.err = ee; ex.tcnt = et; ex.sdone = es; ex.busy_cyc = eb;
    exp_q.push_back(ex);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_test1_steps();
    logic [7:0] vec [8] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
    foreach (vec[i]) step_q.push_back(vec[i]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    rst = 1'b1; start = 1'b0; seed_load = 1'b0; mode = 1'b0;
    seed = 8'h00; tap_mask = 8'h00; steps = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_value", value, 8'h01);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_tap_count", tap_count, 0);
    chk("reset_steps_done", steps_done, 0);

    // Fibonacci, 8 steps from 0x01
    load_seed(8'h01);
    push_test1_steps();
    issue(8'hB8, 8'd8, 1'b0, 8'h1C, 1'b0, 4'd4, 8'd8, 17);
    wait_done(100);

    // Full period: back to 0x01 after 255 steps
    load_seed(8'h01);
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      v = {v[6:0], ^(v & 8'hB8)};
      step_q.push_back(v);
    end
    issue(8'hB8, 8'd255, 1'b0, 8'h01, 1'b0, 4'd4, 8'd255, 264);
    wait_done(400);

    // Galois single steps
    load_seed(8'h80);
    step_q.push_back(8'h1D);
    issue(8'h1D, 8'd1, 1'b1, 8'h1D, 1'b0, 4'd4, 8'd1, 10);
    wait_done(100);
    step_q.push_back(8'h3A);
    issue(8'h1D, 8'd1, 1'b1, 8'h3A, 1'b0, 4'd4, 8'd1, 10);
    wait_done(100);

    // Error runs: empty mask, then zero seed
    issue(8'h00, 8'd5, 1'b0, 8'h3A, 1'b1, 4'd0, 8'd0, 9);
    wait_done(100);
    load_seed(8'h00);
    issue(8'hB8, 8'd5, 1'b0, 8'h00, 1'b1, 4'd4, 8'd0, 9);
    wait_done(100);

    // Disturbance mid-RUN must not affect the run
    load_seed(8'h01);
    push_test1_steps();
    issue(8'hB8, 8'd8, 1'b0, 8'h1C, 1'b0, 4'd4, 8'd8, 17);
    repeat (10) @(negedge clk);
    start = 1'b1; seed_load = 1'b1; seed = 8'h55; tap_mask = 8'hFF; mode = 1'b1; steps = 8'd3;
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0;
    wait_done(100);

    // Reset mid-RUN aborts with no done pulse
    load_seed(8'h01);
    @(negedge clk);
    tap_mask = 8'hB8; steps = 8'd20; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("midrun_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_value", value, 8'h01);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_steps_done", steps_done, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Same-cycle seed_load and start with zero steps; start during done ignored
    load_seed(8'h77);
    @(negedge clk);
    seed_load = 1'b1; seed = 8'h01; start = 1'b1; tap_mask = 8'hB8; steps = 8'd0; mode = 1'b0;
    begin
      exp_t ex;
      ex.value = 8'h01; ex.err = 1'b0; ex.tcnt = 4'd4; ex.sdone = 8'd0; ex.busy_cyc = 9;
      exp_q.push_back(ex);
    end
    @(negedge clk);
    seed_load = 1'b0; start = 1'b0;
    wait_done(100);
    start = 1'b1; tap_mask = 8'h00; steps = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("done_cycle_start_ignored", busy, 0);
    end
    chk("err_after_ignored_start", err, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("steps_drained", step_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
